// File: rtl/dmem_access_unit.sv
// Load/store unit between the CPU datapath and a word-addressed data memory.
// Byte/halfword/word accesses at byte addresses are turned into word-index
// accesses. Sub-word stores use read-modify-write so the memory needs only a
// single word-wide write enable. Bad accesses are reported and never reach memory.
module dmem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rword;
  logic [1:0]  r_size;
  logic        r_we, r_uns, r_err;
  logic        w_accept, w_err;

  // Misaligned, illegal size or word index beyond the end of memory.
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (size == 2'b11) ||
          ((size == 2'b01) && addr[0]) ||
          ((size == 2'b10) && (addr[1:0] != 2'b00)) ||
          ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
    return bad;
  endfunction

  // Replace the addressed little-endian lane(s) of the old word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] rword, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = rword;
    case (size)
      2'b00:   m[{lane, 3'b000} +: 8]        = wdata[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Extract the addressed lane(s) and sign- or zero-extend; word loads ignore uns.
  function automatic logic [31:0] load_extend(input logic [31:0] rword, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh, res;
    res = rword;
    case (size)
      2'b00: begin
        sh  = rword >> {lane, 3'b000};
        res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = rword >> {lane[1], 4'b0000};
        res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = rword;
    endcase
    return res;
  endfunction

  assign w_accept = req_valid && req_ready;
  assign w_err    = req_error(req_size, req_addr);

  // State register; asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Request latches captured on accept; read word captured at the end of READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_rword <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_err   <= w_err;
      end
      if (r_state == READ) r_rword <= mem_rd;
    end
  end

  // Next-state decode and all outputs, derived from the current state.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    mem_a      = {2'b00, r_addr[31:2]};
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                          w_next = RESP;
          else if (req_we && req_size == 2'b10) w_next = WRITE;
          else                                w_next = READ;
        end
      end
      READ: begin
        w_next = r_we ? WRITE : RESP;
      end
      WRITE: begin
        mem_we = 1'b1;
        mem_wd = merge_store(r_rword, r_wdata, r_size, r_addr[1:0]);
        w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_we && !r_err) resp_rdata = load_extend(r_rword, r_size, r_addr[1:0], r_uns);
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural 256-word memory.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  int          t_resp_cyc, t_we_cyc, t_we_cnt;
  logic [31:0] t_rdata, t_mem_a, t_mem_wd;
  logic        t_err;

  dmem_access_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_a < 32'd256) mem[mem_a[7:0]] <= mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and observe up to 8 cycles after the accept edge.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int  n;
    bit  done;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_unsigned = ~uns;
    req_addr = 32'h0000_0000; req_wdata = 32'hA5A5_A5A5;
    t_resp_cyc = 0; t_we_cyc = 0; t_we_cnt = 0; t_rdata = 'x; t_err = 1'bx;
    t_mem_a = 'x; t_mem_wd = 'x;
    done = 0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (mem_we) begin
        t_we_cnt++; t_we_cyc = c; t_mem_a = mem_a; t_mem_wd = mem_wd;
      end
      if (resp_valid) begin
        t_resp_cyc = c; t_rdata = resp_rdata; t_err = resp_err; done = 1;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    run_req(1'b0, size, uns, addr, 32'h0);
    chk({tag, "_cyc"}, t_resp_cyc, 2);
    chk({tag, "_rdata"}, t_rdata, exp);
    chk({tag, "_err"}, {31'h0, t_err}, 0);
    chk({tag, "_nowe"}, t_we_cnt, 0);
  endtask

  task automatic do_bad(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    run_req(we, size, 1'b0, addr, 32'h1234_5678);
    chk({tag, "_cyc"}, t_resp_cyc, 1);
    chk({tag, "_err"}, {31'h0, t_err}, 1);
    chk({tag, "_rdata"}, t_rdata, 0);
    chk({tag, "_nowe"}, t_we_cnt, 0);
  endtask

  int we_seen, resp_seen;
  int we_k [2];
  int resp_k [2];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h8899_AABB;

    // Reset values
    #12;
    chk("rst_ready", {31'h0, req_ready}, 1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", {31'h0, resp_err}, 0);
    chk("rst_mem_we", {31'h0, mem_we}, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads from word 1
    do_load("lw4",  2'b10, 1'b0, 32'h4, 32'h8899_AABB);
    do_load("lb7",  2'b00, 1'b0, 32'h7, 32'hFFFF_FF88);
    do_load("lbu7", 2'b00, 1'b1, 32'h7, 32'h0000_0088);
    do_load("lh6",  2'b01, 1'b0, 32'h6, 32'hFFFF_8899);
    do_load("lhu4", 2'b01, 1'b1, 32'h4, 32'h0000_AABB);
    do_load("lb4",  2'b00, 1'b0, 32'h4, 32'hFFFF_FFBB);
    do_load("lwu4", 2'b10, 1'b1, 32'h4, 32'h8899_AABB);

    // Byte store via read-modify-write
    run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_0012);
    chk("sb5_we_cyc", t_we_cyc, 2);
    chk("sb5_we_cnt", t_we_cnt, 1);
    chk("sb5_mem_a", t_mem_a, 1);
    chk("sb5_mem_wd", t_mem_wd, 32'h8899_12BB);
    chk("sb5_resp_cyc", t_resp_cyc, 3);
    chk("sb5_rdata", t_rdata, 0);
    do_load("lw4_after_sb", 2'b10, 1'b0, 32'h4, 32'h8899_12BB);

    // Halfword store to the upper half
    run_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_CAFE);
    chk("sh6_we_cyc", t_we_cyc, 2);
    chk("sh6_mem_wd", t_mem_wd, 32'hCAFE_12BB);
    chk("sh6_resp_cyc", t_resp_cyc, 3);
    do_load("lw4_after_sh", 2'b10, 1'b0, 32'h4, 32'hCAFE_12BB);

    // Misaligned, illegal size, out of range
    do_bad("lw6", 1'b0, 2'b10, 32'h6);
    do_bad("sh3", 1'b1, 2'b01, 32'h3);
    do_bad("sz11", 1'b0, 2'b11, 32'h4);
    do_bad("sw400", 1'b1, 2'b10, 32'h400);
    chk("word0_kept", mem[0], 32'hDEAD_BEEF);
    chk("word1_kept", mem[1], 32'hCAFE_12BB);

    // Back-to-back word stores with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    req_addr = 32'hC; req_wdata = 32'h2222_2222;
    we_seen = 0; resp_seen = 0;
    we_k[0] = 0; we_k[1] = 0; resp_k[0] = 0; resp_k[1] = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("b2b_ready_k1", {31'h0, req_ready}, 0);
      if (k == 2) chk("b2b_ready_k2", {31'h0, req_ready}, 0);
      if (k == 3) chk("b2b_ready_k3", {31'h0, req_ready}, 1);
      if (k == 4) req_valid = 1'b0;
      if (mem_we)     begin if (we_seen < 2) we_k[we_seen] = k; we_seen++; end
      if (resp_valid) begin if (resp_seen < 2) resp_k[resp_seen] = k; resp_seen++; end
    end
    chk("b2b_we_cnt", we_seen, 2);
    chk("b2b_resp_cnt", resp_seen, 2);
    chk("b2b_we0", we_k[0], 1);
    chk("b2b_resp0", resp_k[0], 2);
    chk("b2b_we1", we_k[1], 4);
    chk("b2b_resp1", resp_k[1], 5);
    chk("b2b_word2", mem[2], 32'h1111_1111);
    chk("b2b_word3", mem[3], 32'h2222_2222);

    // Reset asserted during the WRITE of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h0000_5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_write", {31'h0, mem_we}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'h0, mem_we}, 0);
    chk("abort_no_resp", {31'h0, resp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", {31'h0, req_ready}, 1);
    resp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    chk("abort_resp_cnt", resp_seen, 0);
    chk("abort_word1", mem[1], 32'hCAFE_12BB);
    do_load("lw4_after_abort", 2'b10, 1'b0, 32'h4, 32'hCAFE_12BB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
